// File: rtl/dma_mem2mem_ctrl_pkg.sv
// dma_pkg: shared types and helpers for the memory-to-memory DMA sequencer.
//   dma_state_e  : sequencer state encoding
//   addr_step_e  : per-byte address step mode (increment / decrement / hold)
//   addr_step()  : applies a step mode; callers truncate the result to their
//                  own width, which gives modulo-2^width wrap for free
package dma_pkg;
   localparam int DMA_ADDR_W = 16;
   localparam int DMA_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_e;

   typedef enum logic [1:0] {
      STEP_INC  = 2'd0,
      STEP_DEC  = 2'd1,
      STEP_HOLD = 2'd2
   } addr_step_e;

   function automatic logic [31:0] addr_step(input logic [31:0] a, input addr_step_e mode);
      case (mode)
         STEP_INC: return a + 32'd1;
         STEP_DEC: return a - 32'd1;
         default:  return a;
      endcase
   endfunction
endpackage

// File: rtl/dma_mem2mem_ctrl_if.sv
// dma_mem2mem_ctrl_if: request/config inputs and memory-bus strobes of the
// mem-to-mem DMA sequencer.
//   master : the sequencer (drives addr, memr_n, memw_n, mem2mem, busy, tc, aborted)
//   slave  : the requester / memory side (drives start, config, ready, eop_n)
interface dma_mem2mem_ctrl_if
   import dma_pkg::*;
#(
   parameter int ADDR_W = DMA_ADDR_W,
   parameter int CNT_W  = DMA_CNT_W
);
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [CNT_W-1:0]  count;
   logic              src_hold;
   logic              addr_dec;
   logic              ready;
   logic              eop_n;
   logic [ADDR_W-1:0] addr;
   logic              memr_n;
   logic              memw_n;
   logic              mem2mem;
   logic              busy;
   logic              tc;
   logic              aborted;

   modport master (
      input  start, src_addr, dst_addr, count, src_hold, addr_dec, ready, eop_n,
      output addr, memr_n, memw_n, mem2mem, busy, tc, aborted
   );

   modport slave (
      output start, src_addr, dst_addr, count, src_hold, addr_dec, ready, eop_n,
      input  addr, memr_n, memw_n, mem2mem, busy, tc, aborted
   );
endinterface

// File: rtl/dma_mem2mem_ctrl_addr_counter.sv
// dma_addr_counter: loadable address counter with step mode latched at load.
//   clk, rst_n   : clock, async active-low reset
//   i_load       : load i_load_addr and i_load_mode
//   i_load_addr  : start address
//   i_load_mode  : increment / decrement / hold for the whole block
//   i_step       : advance one step in the latched mode
//   o_addr       : current address
module dma_addr_counter
   import dma_pkg::*;
#(
   parameter int ADDR_W = DMA_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  addr_step_e        i_load_mode,
   input  logic              i_step,
   output logic [ADDR_W-1:0] o_addr
);
   logic [ADDR_W-1:0] r_addr;
   addr_step_e        r_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_mode <= STEP_INC;
      end else if (i_load) begin
         r_addr <= i_load_addr;
         r_mode <= i_load_mode;
      end else if (i_step) begin
         r_addr <= ADDR_W'(addr_step(32'(r_addr), r_mode));
      end
   end

   assign o_addr = r_addr;
endmodule

// File: rtl/dma_mem2mem_ctrl.sv
// dma_mem2mem_ctrl: sequences memory-to-memory DMA, one byte per READ+WRITE
// phase pair through an external temporary register.
//   clk, rst_n : clock, async active-low reset
//   bus        : master modport (start/config/ready/eop_n in; addr, memr_n,
//                memw_n, mem2mem, busy, tc, aborted out)
//
// state | meaning
// IDLE  | waiting for start
// READ  | source address on bus, memr_n low, temp register captures on ready
// WRITE | destination address on bus, memw_n low, temp register drives on ready
// DONE  | one quiet cycle after the block, start ignored
module dma_mem2mem_ctrl
   import dma_pkg::*;
#(
   parameter int ADDR_W = DMA_ADDR_W,
   parameter int CNT_W  = DMA_CNT_W
) (
   input logic                clk,
   input logic                rst_n,
   dma_mem2mem_ctrl_if.master bus
);
   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_READ  = ST_READ;
   localparam logic [1:0] S_WRITE = ST_WRITE;
   localparam logic [1:0] S_DONE  = ST_DONE;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  r_remaining;
   logic [ADDR_W-1:0] w_src;
   logic [ADDR_W-1:0] w_dst;
   logic              w_rd;
   logic              w_wr;
   logic              w_accept;
   logic              w_wr_done;
   logic              w_last;
   logic              w_eop;
   addr_step_e        w_src_mode;
   addr_step_e        w_dst_mode;

   assign w_rd      = (r_state == S_READ);
   assign w_wr      = (r_state == S_WRITE);
   assign w_accept  = (r_state == S_IDLE) && bus.start;
   assign w_wr_done = w_wr && bus.ready;
   assign w_last    = (r_remaining == '0);
   assign w_eop     = (w_rd || w_wr) && !bus.eop_n;

   assign w_dst_mode = bus.addr_dec ? STEP_DEC : STEP_INC;
   assign w_src_mode = bus.src_hold ? STEP_HOLD : w_dst_mode;

   dma_addr_counter #(.ADDR_W(ADDR_W)) u_src_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_accept),
      .i_load_addr (bus.src_addr),
      .i_load_mode (w_src_mode),
      .i_step      (w_wr_done),
      .o_addr      (w_src)
   );

   dma_addr_counter #(.ADDR_W(ADDR_W)) u_dst_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_accept),
      .i_load_addr (bus.dst_addr),
      .i_load_mode (w_dst_mode),
      .i_step      (w_wr_done),
      .o_addr      (w_dst)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_READ;
         S_READ: begin
            if (w_eop)          w_state_nxt = S_DONE;
            else if (bus.ready) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (w_eop || (w_wr_done && w_last)) w_state_nxt = S_DONE;
            else if (w_wr_done)                  w_state_nxt = S_READ;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept)
            r_remaining <= bus.count;
         else if (w_wr_done && !w_last)
            r_remaining <= r_remaining - 1'b1;
      end
   end

   // All outputs decode from state so an async reset clears them at once.
   // A write completing alongside eop_n still counts, so tc ignores eop_n.
   assign bus.addr    = w_rd ? w_src : (w_wr ? w_dst : '0);
   assign bus.memr_n  = !w_rd;
   assign bus.memw_n  = !w_wr;
   assign bus.mem2mem = (w_rd || w_wr) && bus.ready;
   assign bus.busy    = w_rd || w_wr;
   assign bus.tc      = w_wr_done && w_last;
   assign bus.aborted = w_eop;
endmodule

// File: tb/tb_dma_mem2mem_ctrl.sv
module tb_dma_mem2mem_ctrl;
   import dma_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dma_mem2mem_ctrl_if #(.ADDR_W(16), .CNT_W(16)) bus ();
   dma_mem2mem_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_pass = 0;
   int n_total = 0;

   logic [15:0] q_addr[$];
   logic        q_rd[$];
   int n_act, n_memr, n_memw, n_m2m_r, n_m2m_w, n_tc, n_ab, tc_cyc, ab_cyc, n_conflict;
   bit timeout, done_quiet;
   logic [7:0] mem [int];
   logic [7:0] temp_reg;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_block(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c,
                              input logic hold, input logic dec);
      bus.src_addr = s; bus.dst_addr = d; bus.count = c;
      bus.src_hold = hold; bus.addr_dec = dec; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Drives ready/eop_n per cycle, records bus activity and models the
   // temporary register and memory until busy drops or the budget expires.
   task automatic run_block(input int max_cyc, input logic [63:0] rdy, input int eop_cyc, input int start_cyc);
      q_addr.delete(); q_rd.delete();
      n_act = 0; n_memr = 0; n_memw = 0; n_m2m_r = 0; n_m2m_w = 0;
      n_tc = 0; n_ab = 0; tc_cyc = -1; ab_cyc = -1; n_conflict = 0;
      timeout = 1'b1; done_quiet = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         bus.ready = rdy[c];
         bus.eop_n = (c == eop_cyc) ? 1'b0 : 1'b1;
         bus.start = (c == start_cyc);
         if (c == start_cyc) begin
            bus.src_addr = 16'h9999; bus.dst_addr = 16'h8888; bus.count = 16'h0040;
         end
         #1;
         if (!bus.busy) begin
            timeout = 1'b0;
            done_quiet = bus.memr_n && bus.memw_n && !bus.mem2mem && !bus.tc && !bus.aborted;
            break;
         end
         n_act++;
         q_addr.push_back(bus.addr);
         q_rd.push_back(!bus.memr_n);
         if (!bus.memr_n) n_memr++;
         if (!bus.memw_n) n_memw++;
         if (!bus.memr_n && bus.mem2mem) begin
            n_m2m_r++;
            temp_reg = mem.exists(int'(bus.addr)) ? mem[int'(bus.addr)] : 8'h00;
         end
         if (!bus.memw_n && bus.mem2mem) begin
            n_m2m_w++;
            mem[int'(bus.addr)] = temp_reg;
         end
         if (!bus.memr_n && !bus.memw_n) n_conflict++;
         if (bus.tc) begin n_tc++; tc_cyc = c; end
         if (bus.aborted) begin n_ab++; ab_cyc = c; end
         @(posedge clk); #1;
      end
      bus.start = 1'b0; bus.eop_n = 1'b1; bus.ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.src_addr = 16'h1234; bus.dst_addr = 16'h5678; bus.count = 16'h0003;
      bus.src_hold = 1'b0; bus.addr_dec = 1'b0; bus.ready = 1'b1; bus.eop_n = 1'b1;
      #12;
      n_total++; if (bus.addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", bus.addr); else n_pass++;
      n_total++; if (bus.memr_n !== 1'b1) $display("FAIL reset_memr_n: got %b want 1", bus.memr_n); else n_pass++;
      n_total++; if (bus.memw_n !== 1'b1) $display("FAIL reset_memw_n: got %b want 1", bus.memw_n); else n_pass++;
      n_total++; if (bus.mem2mem !== 1'b0) $display("FAIL reset_mem2mem: got %b want 0", bus.mem2mem); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
      n_total++; if (bus.tc !== 1'b0 || bus.aborted !== 1'b0)
         $display("FAIL reset_pulses: got tc=%b aborted=%b want 0/0", bus.tc, bus.aborted); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_inc();
      logic [15:0] exp_a[6] = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0102, 16'h0202};
      start_block(16'h0100, 16'h0200, 16'd2, 1'b0, 1'b0);
      run_block(30, 64'hFFFF_FFFF_FFFF_FFFF, -1, 2);
      n_total++; if (timeout) $display("FAIL basic_timeout: busy still high after 30 cycles, want low"); else n_pass++;
      n_total++; if (n_act !== 6) $display("FAIL basic_active: got %0d want 6", n_act); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (i >= q_addr.size() || q_addr[i] !== exp_a[i])
            $display("FAIL basic_addr[%0d]: got %h want %h", i, (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, exp_a[i]);
         else n_pass++;
      end
      n_total++; if (q_rd.size() == 0 || q_rd[0] !== 1'b1) $display("FAIL basic_first_read: memr_n not low in first cycle after start"); else n_pass++;
      n_total++; if (n_memr !== 3 || n_memw !== 3) $display("FAIL basic_strobes: got r=%0d w=%0d want 3/3", n_memr, n_memw); else n_pass++;
      n_total++; if (n_tc !== 1 || tc_cyc !== 5) $display("FAIL basic_tc: got n=%0d cyc=%0d want 1/5", n_tc, tc_cyc); else n_pass++;
      n_total++; if (n_ab !== 0) $display("FAIL basic_aborted: got %0d want 0", n_ab); else n_pass++;
      n_total++; if (!done_quiet) $display("FAIL basic_done_quiet: strobes active in DONE, want all idle"); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_wait_states();
      mem[int'(16'h0700)] = 8'hA5;
      mem[int'(16'h0800)] = 8'h00;
      start_block(16'h0700, 16'h0800, 16'd0, 1'b0, 1'b0);
      run_block(30, 64'h14, -1, -1);
      n_total++; if (n_act !== 5) $display("FAIL wait_active: got %0d want 5", n_act); else n_pass++;
      n_total++; if (n_memr !== 3) $display("FAIL wait_memr: got %0d want 3", n_memr); else n_pass++;
      n_total++; if (n_memw !== 2) $display("FAIL wait_memw: got %0d want 2", n_memw); else n_pass++;
      n_total++; if (n_m2m_r !== 1 || n_m2m_w !== 1) $display("FAIL wait_mem2mem: got r=%0d w=%0d want 1/1", n_m2m_r, n_m2m_w); else n_pass++;
      n_total++; if (n_tc !== 1 || tc_cyc !== 4) $display("FAIL wait_tc: got n=%0d cyc=%0d want 1/4", n_tc, tc_cyc); else n_pass++;
      n_total++; if (mem[int'(16'h0800)] !== 8'hA5) $display("FAIL temp_reg_data: got %h want a5", mem[int'(16'h0800)]); else n_pass++;
      n_total++; if (n_conflict !== 0) $display("FAIL data_bus_conflict: got %0d want 0", n_conflict); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_fill_dec();
      logic [15:0] exp_a[6] = '{16'h0010, 16'h0001, 16'h0010, 16'h0000, 16'h0010, 16'hFFFF};
      start_block(16'h0010, 16'h0001, 16'd2, 1'b1, 1'b1);
      run_block(30, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
      n_total++; if (n_act !== 6) $display("FAIL fill_active: got %0d want 6", n_act); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (i >= q_addr.size() || q_addr[i] !== exp_a[i])
            $display("FAIL fill_addr[%0d]: got %h want %h", i, (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, exp_a[i]);
         else n_pass++;
      end
      n_total++; if (n_tc !== 1) $display("FAIL fill_tc: got %0d want 1", n_tc); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap_inc();
      logic [15:0] exp_a[4] = '{16'hFFFF, 16'hFFFE, 16'h0000, 16'hFFFF};
      start_block(16'hFFFF, 16'hFFFE, 16'd1, 1'b0, 1'b0);
      run_block(30, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
      n_total++; if (n_act !== 4) $display("FAIL wrap_active: got %0d want 4", n_act); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (i >= q_addr.size() || q_addr[i] !== exp_a[i])
            $display("FAIL wrap_addr[%0d]: got %h want %h", i, (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, exp_a[i]);
         else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      start_block(16'h0300, 16'h0400, 16'd5, 1'b0, 1'b0);
      run_block(40, 64'hFFFF_FFFF_FFFF_FFFF, 4, -1);
      n_total++; if (timeout) $display("FAIL abort_timeout: busy still high after 40 cycles, want low"); else n_pass++;
      n_total++; if (n_act !== 5) $display("FAIL abort_active: got %0d want 5", n_act); else n_pass++;
      n_total++; if (n_memw !== 2) $display("FAIL abort_memw: got %0d want 2", n_memw); else n_pass++;
      n_total++; if (n_tc !== 0) $display("FAIL abort_tc: got %0d want 0", n_tc); else n_pass++;
      n_total++; if (n_ab !== 1 || ab_cyc !== 4) $display("FAIL abort_pulse: got n=%0d cyc=%0d want 1/4", n_ab, ab_cyc); else n_pass++;
      n_total++; if (!done_quiet) $display("FAIL abort_done_quiet: strobes active in DONE, want all idle"); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_abort_last();
      mem[int'(16'h0900)] = 8'h3C;
      mem[int'(16'h0A00)] = 8'h00;
      start_block(16'h0900, 16'h0A00, 16'd0, 1'b0, 1'b0);
      run_block(20, 64'hFFFF_FFFF_FFFF_FFFF, 1, -1);
      n_total++; if (n_act !== 2) $display("FAIL abort_last_active: got %0d want 2", n_act); else n_pass++;
      n_total++; if (n_tc !== 1 || n_ab !== 1) $display("FAIL abort_last_pulses: got tc=%0d ab=%0d want 1/1", n_tc, n_ab); else n_pass++;
      n_total++; if (mem[int'(16'h0A00)] !== 8'h3C) $display("FAIL abort_last_data: got %h want 3c", mem[int'(16'h0A00)]); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp_a[2] = '{16'h0500, 16'h0600};
      bus.ready = 1'b1; bus.eop_n = 1'b1;
      start_block(16'h0B00, 16'h0C00, 16'd3, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_total++; if (bus.memw_n !== 1'b0) $display("FAIL midrst_in_write: got memw_n=%b want 0", bus.memw_n); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_total++; if (bus.memw_n !== 1'b1 || bus.mem2mem !== 1'b0)
         $display("FAIL midrst_strobes: got memw_n=%b mem2mem=%b want 1/0", bus.memw_n, bus.mem2mem); else n_pass++;
      n_total++; if (bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.addr !== 16'h0000)
         $display("FAIL midrst_state: got busy=%b tc=%b addr=%h want 0/0/0000", bus.busy, bus.tc, bus.addr); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_idle: got busy=%b want 0", bus.busy); else n_pass++;
      start_block(16'h0500, 16'h0600, 16'd0, 1'b0, 1'b0);
      run_block(20, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
      n_total++; if (n_act !== 2 || n_tc !== 1) $display("FAIL midrst_fresh: got act=%0d tc=%0d want 2/1", n_act, n_tc); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (i >= q_addr.size() || q_addr[i] !== exp_a[i])
            $display("FAIL midrst_addr[%0d]: got %h want %h", i, (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, exp_a[i]);
         else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic_inc();
      test_wait_states();
      test_fill_dec();
      test_wrap_inc();
      test_abort();
      test_abort_last();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dma_mem2mem_ctrl.md
Name: dma_mem2mem_ctrl

Overview:
Sequencer for DMA memory-to-memory transfers. Each byte moves in two bus phases: a READ phase that gates source memory data onto the shared 8-bit Data bus into the temporary register, then a WRITE phase in which the temporary register drives the bus into destination memory. The block owns addresses, MEMR_n/MEMW_n, the mem2mem strobe to the temporary register, byte counting and terminal count. It never touches the Data bus itself.

Parameters:
ADDR_W, 16, width of source/destination/bus address.
CNT_W, 16, width of transfer count; count value N moves N+1 bytes.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a block; sampled only in IDLE
src_addr  input  ADDR_W  first source address, latched on accepted start
dst_addr  input  ADDR_W  first destination address, latched on accepted start
count  input  CNT_W  bytes minus one, latched on accepted start
src_hold  input  1  1 = source address fixed (fill mode), latched on start
addr_dec  input  1  1 = addresses decrement, 0 = increment, latched on start
ready  input  1  memory ready; low stretches the current phase
eop_n  input  1  external abort, active low
addr  output  ADDR_W  bus address
memr_n  output  1  memory read strobe, active low
memw_n  output  1  memory write strobe, active low
mem2mem  output  1  strobe to temporary register: capture/drive enable
busy  output  1  high from accepted start until return to IDLE
tc  output  1  one-cycle pulse when the last byte's WRITE completes
aborted  output  1  one-cycle pulse when eop_n terminates a block

Behaviour:
- Reset (async, rst_n=0): state IDLE; addr=0, memr_n=1, memw_n=1, mem2mem=0, busy=0, tc=0, aborted=0; latched registers cleared. Reset mid-block drops all strobes immediately, with no completion pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE: start=1 latches the inputs and goes to READ next cycle. busy rises in the same edge.
- READ: addr=cur_src, memr_n=0, memw_n=1. mem2mem = ready, combinational, so the temporary register sees exactly one qualified capture cycle. ready=0 holds READ with memr_n still low. ready=1 moves to WRITE.
- WRITE: addr=cur_dst, memw_n=0, memr_n=1, mem2mem = ready. On ready=1:
  - cur_dst steps by one (+1, or -1 if addr_dec).
  - cur_src steps the same way unless src_hold.
  - If remaining==0: pulse tc and go to DONE. Otherwise decrement remaining and go to READ.
- DONE: all strobes inactive, busy=0. Return to IDLE next cycle. start is ignored in DONE.
- Minimum throughput: 2 cycles per byte with ready tied high. Latency from start to first memr_n low is 1 cycle.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000, and 0x0000-1 wraps to 0xFFFF. There is no error on wrap.
- count=0 moves exactly one byte. count=all-ones moves 2^CNT_W bytes.
- eop_n=0 sampled in READ or WRITE:
  - Abort at the next edge, whatever the ready value, and go to DONE with a one-cycle aborted pulse.
  - A WRITE that completes in the same cycle as eop_n=0 still counts. If it was the last byte, tc and aborted both pulse.
  - An aborted READ does not write.
- eop_n is ignored in IDLE and DONE.
- start during busy is ignored with no queuing.
- mem2mem is never high in IDLE or DONE, and never high while ready=0.

Decomposition:
- Shared package dma_pkg holds:
  - the state encoding enum (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3);
  - the default ADDR_W/CNT_W constants;
  - the address-step helper function (inc/dec/hold, modulo width).
- One sub-module is natural: dma_addr_counter, a loadable up/down/hold counter. It is instantiated twice, for source and destination.
- The byte counter stays inline.

Test Plan:
- Basic increment: src=0x0100, dst=0x0200, count=2, ready=1 → addr sequence 0100,0200,0101,0201,0102,0202; 6 active cycles; tc pulses on the third WRITE; busy low 1 cycle later.
- Wait states: count=0, ready low for 2 cycles in READ and 1 cycle in WRITE → memr_n low 3 cycles, memw_n low 2 cycles, mem2mem high exactly 1 cycle in each phase, one tc.
- Fill and decrement: src_hold=1, addr_dec=1, src=0x0010, dst=0x0001, count=2 → source stays at 0x0010; destination goes 0001,0000,FFFF (wraps).
- Abort: count=5, eop_n low during the READ of byte 3 → aborted pulse, no tc, exactly 2 memw_n pulses, busy drops.
- Reset mid-block: rst_n low during WRITE → memw_n=1 and mem2mem=0 asynchronously, before the next clk. After release, the block is in IDLE and start begins a fresh block from the newly latched addresses.
- Against the temporary register model: memory holds 0xA5 at src → destination memory receives 0xA5, and the Data bus is never double-driven.
